// File: rtl/mmwave_cfg_cmd_parser.sv
// mmwave_cfg_cmd_parser
//   Parses configuration frames from a UART RX byte stream and turns each
//   accepted frame into a single configuration register write.
//
//   Frame layout (11 bytes):
//     HEADER_BYTE, INDEX, P7 (MSB) .. P0 (LSB), CHK
//   CHK is the XOR of INDEX and all eight payload bytes. The header is not
//   included in CHK.
//
// Ports
//   clk                    : single clock; all logic runs on its rising edge
//   rst_n                  : asynchronous active-low reset
//   rx_valid_i             : one-cycle strobe; rx_data_i holds a received byte
//   rx_data_i[7:0]         : received byte
//   mmwave_cfg_wr_en_o     : one-cycle config write strobe
//   mmwave_cfg_wr_index_o  : config register index (0..5); held between writes
//   mmwave_cfg_wr_value_o  : config register value; held between writes
//   cmd_ok_o               : one-cycle pulse, frame accepted
//   cmd_err_o              : one-cycle pulse, frame rejected
//   cmd_err_code_o         : reason for the last rejection
//                            (1 bad index, 2 bad checksum, 3 timeout)
//
// Handshake: there is no backpressure. A byte is consumed on every rising
// edge where rx_valid_i is high. All outputs are registered, so the result
// of the byte consumed at edge N appears in the cycle after edge N.
module mmwave_cfg_cmd_parser #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
  parameter logic [7:0]  HEADER_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        mmwave_cfg_wr_en_o,
  output logic [2:0]  mmwave_cfg_wr_index_o,
  output logic [63:0] mmwave_cfg_wr_value_o,
  output logic        cmd_ok_o,
  output logic        cmd_err_o,
  output logic [1:0]  cmd_err_code_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INDEX   = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_INDEX   = 2'd1;
  localparam logic [1:0] ERR_CHKSUM  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_t      state;
  logic [2:0]  byte_cnt;   // payload byte position, 0..7
  logic [7:0]  chk_acc;    // running XOR of INDEX and payload bytes
  logic [63:0] shift_reg;  // payload assembly, newest byte in [7:0]
  logic [2:0]  idx_reg;    // index captured from the INDEX byte
  logic [31:0] tmo_cnt;    // idle clocks since the last byte of this frame

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      byte_cnt              <= 3'd0;
      chk_acc               <= 8'd0;
      shift_reg             <= 64'd0;
      idx_reg               <= 3'd0;
      tmo_cnt               <= 32'd0;
      mmwave_cfg_wr_en_o    <= 1'b0;
      mmwave_cfg_wr_index_o <= 3'd0;
      mmwave_cfg_wr_value_o <= 64'd0;
      cmd_ok_o              <= 1'b0;
      cmd_err_o             <= 1'b0;
      cmd_err_code_o        <= 2'd0;
    end else begin
      // Pulses default low; at most one of ok/err is set per edge below.
      mmwave_cfg_wr_en_o <= 1'b0;
      cmd_ok_o           <= 1'b0;
      cmd_err_o          <= 1'b0;

      if (state == ST_IDLE || rx_valid_i) begin
        tmo_cnt <= 32'd0;
      end else begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end

      if (rx_valid_i) begin
        // A byte arriving on the very cycle the counter hits the limit
        // takes this branch, so it is processed rather than timed out.
        case (state)
          ST_IDLE: begin
            if (rx_data_i == HEADER_BYTE) begin
              state <= ST_INDEX;
            end
          end
          ST_INDEX: begin
            if (rx_data_i <= 8'd5) begin
              idx_reg  <= rx_data_i[2:0];
              chk_acc  <= rx_data_i;
              byte_cnt <= 3'd0;
              state    <= ST_PAYLOAD;
            end else begin
              cmd_err_o      <= 1'b1;
              cmd_err_code_o <= ERR_INDEX;
              state          <= ST_IDLE;
            end
          end
          ST_PAYLOAD: begin
            // Header value is plain data here; no resynchronisation.
            shift_reg <= {shift_reg[55:0], rx_data_i};
            chk_acc   <= chk_acc ^ rx_data_i;
            byte_cnt  <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd7) begin
              state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (rx_data_i == chk_acc) begin
              mmwave_cfg_wr_en_o    <= 1'b1;
              cmd_ok_o              <= 1'b1;
              mmwave_cfg_wr_index_o <= idx_reg;
              mmwave_cfg_wr_value_o <= shift_reg;
            end else begin
              cmd_err_o      <= 1'b1;
              cmd_err_code_o <= ERR_CHKSUM;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE && tmo_cnt >= TIMEOUT_CYCLES) begin
        cmd_err_o      <= 1'b1;
        cmd_err_code_o <= ERR_TIMEOUT;
        state          <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mmwave_cfg_cmd_parser.sv
// Testbench for mmwave_cfg_cmd_parser.
// Directed frames drive the DUT; every frame that should produce an ok or err
// pulse pushes a 72-bit expected output snapshot and the edge number it must
// appear on. A monitor on the falling edge pops and compares whenever any
// pulse output is high, and flags any pulse that was not expected.
// Snapshot layout: {wr_en, ok, err, err_code[1:0], index[2:0], value[63:0]}.
module tb_mmwave_cfg_cmd_parser;

  localparam int W = 72;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        wr_en;
  logic [2:0]  wr_index;
  logic [63:0] wr_value;
  logic        cmd_ok;
  logic        cmd_err;
  logic [1:0]  err_code;

  mmwave_cfg_cmd_parser #(
    .TIMEOUT_CYCLES(32'd16),
    .HEADER_BYTE   (8'hA5)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rx_valid_i           (rx_valid),
    .rx_data_i            (rx_data),
    .mmwave_cfg_wr_en_o   (wr_en),
    .mmwave_cfg_wr_index_o(wr_index),
    .mmwave_cfg_wr_value_o(wr_value),
    .cmd_ok_o             (cmd_ok),
    .cmd_err_o            (cmd_err),
    .cmd_err_code_o       (err_code)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           checks = 0;
  int           failures = 0;

  // Model of the held outputs (last written index/value, last error code).
  logic [2:0]  m_idx = 3'd0;
  logic [63:0] m_val = 64'd0;
  logic [1:0]  m_code = 2'd0;

  // ---------------- driver tasks ----------------
  // Drives one byte for the next rising edge; edge_no is that edge's number.
  task automatic drive(input logic [7:0] b, output int edge_no);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    edge_no  = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] idx, input logic [63:0] val,
                            input logic [7:0] chk, output int chk_edge);
    int e;
    drive(8'hA5, e);
    drive(idx, e);
    for (int i = 0; i < 8; i++) drive(val[63-8*i -: 8], e);
    drive(chk, chk_edge);
  endtask

  task automatic expect_ok(input logic [2:0] idx, input logic [63:0] val, input int at);
    m_idx = idx;
    m_val = val;
    exp_q.push_back({1'b1, 1'b1, 1'b0, m_code, idx, val});
    exp_cyc_q.push_back(at);
  endtask

  task automatic expect_err(input logic [1:0] code, input int at);
    m_code = code;
    exp_q.push_back({1'b0, 1'b0, 1'b1, code, m_idx, m_val});
    exp_cyc_q.push_back(at);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    int           exp_c;
    if (rst_n && (wr_en || cmd_ok || cmd_err)) begin
      act = {wr_en, cmd_ok, cmd_err, err_code, wr_index, wr_value};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d actual=%h required=none", cyc, act);
      end else begin
        exp_v = exp_q.pop_front();
        exp_c = exp_cyc_q.pop_front();
        if (act !== exp_v || cyc != exp_c) begin
          failures++;
          $display("FAIL pulse_event actual=%h@%0d required=%h@%0d", act, cyc, exp_v, exp_c);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int e;
    int guard;

    // Reset state: every output low while reset is held.
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_en, cmd_ok, cmd_err, err_code, wr_index, wr_value} !== {W{1'b0}}) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=0",
               {wr_en, cmd_ok, cmd_err, err_code, wr_index, wr_value});
    end
    rst_n = 1'b1;
    idle(2);

    // Valid frame: checksum 02^11^22^33^44^55^66^77^88 = 8A.
    send_frame(8'h02, 64'h1122334455667788, 8'h8A, e);
    expect_ok(3'd2, 64'h1122334455667788, e);

    // Same frame with wrong checksums: error code 2, outputs held.
    send_frame(8'h02, 64'h1122334455667788, 8'h0B, e);
    expect_err(2'd2, e);
    send_frame(8'h02, 64'h1122334455667788, 8'h0A, e);
    expect_err(2'd2, e);

    // Bad index 7: error right after the index byte; next frame accepted.
    drive(8'hA5, e);
    drive(8'h07, e);
    expect_err(2'd1, e);
    send_frame(8'h01, 64'h0102030405060708, 8'h09, e);
    expect_ok(3'd1, 64'h0102030405060708, e);
    idle(3);

    // Noise, then two back-to-back frames. First payload is all header
    // bytes (treated as data): XOR = 00. Second: FF^EE^..^88^05 = 05.
    drive(8'h00, e);
    drive(8'hFF, e);
    send_frame(8'h00, 64'hA5A5A5A5A5A5A5A5, 8'h00, e);
    expect_ok(3'd0, 64'hA5A5A5A5A5A5A5A5, e);
    send_frame(8'h05, 64'hFFEEDDCCBBAA9988, 8'h05, e);
    expect_ok(3'd5, 64'hFFEEDDCCBBAA9988, e);
    idle(2);

    // Timeout boundary: 16 idle clocks then a byte is still processed.
    drive(8'hA5, e);
    drive(8'h03, e);
    drive(8'h11, e);
    idle(16);
    drive(8'h22, e);
    drive(8'h33, e);
    drive(8'h44, e);
    drive(8'h55, e);
    drive(8'h66, e);
    drive(8'h77, e);
    drive(8'h88, e);
    drive(8'h8B, e);  // 03 ^ (payload XOR 88)
    expect_ok(3'd3, 64'h1122334455667788, e);
    idle(2);

    // Timeout: a 17th idle clock aborts the frame with code 3.
    drive(8'hA5, e);
    drive(8'h03, e);
    drive(8'h11, e);
    expect_err(2'd3, e + 17);
    idle(22);

    // Reset mid-frame after the 5th payload byte.
    drive(8'hA5, e);
    drive(8'h04, e);
    for (int i = 1; i <= 5; i++) drive(i[7:0], e);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_en, cmd_ok, cmd_err, err_code, wr_index, wr_value} !== {W{1'b0}}) begin
      failures++;
      $display("FAIL midframe_reset actual=%h required=0",
               {wr_en, cmd_ok, cmd_err, err_code, wr_index, wr_value});
    end
    m_idx  = 3'd0;
    m_val  = 64'd0;
    m_code = 2'd0;
    rst_n  = 1'b1;
    idle(4);

    // Complete frame after reset: 00^11^22^33^44^55^66^77^04 = 04.
    send_frame(8'h04, 64'h0011223344556677, 8'h04, e);
    expect_ok(3'd4, 64'h0011223344556677, e);
    idle(5);

    // Every expected pulse must have been seen.
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses actual_pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
